mem_stage: RTL and testbench

- Memory-access stage of the five-stage LoongArch pipeline, between the execute stage (upstream) and the write-back stage (downstream).
- Accepts one instruction at a time from execute and waits for the data SRAM response when a load or store request was issued.
- Aligns and extends load data, then presents the result, destination and exception type to write-back under a valid/allow_in handshake.
- Drops responses that belong to instructions killed by an exception or ertn flush.

---
 rtl/mem_stage.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of the five-stage LoongArch pipeline.
//
// Takes one instruction at a time from execute. If that instruction issued a
// data SRAM request, the stage waits for the response. It then aligns and
// extends load data and hands the result to write-back under a
// valid/allow_in handshake. Responses that belong to instructions killed by
// a flush are counted and dropped when they arrive.
//
// Optional feature macro: MEM_FWD_EN
//   defined   : result forwarding to decode (mem_fwd_*); mem_load_pending
//               only covers loads whose data has not yet arrived.
//   undefined : forwarding outputs tied to zero; mem_load_pending flags any
//               valid register-writing instruction held in this stage.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   ex_to_mem_valid / mem_allow_in  handshake with execute
//   ex_pc, ex_alu_result, ex_load_op, ex_gr_we, ex_dest,
//   ex_req_issued, ex_ex_type   payload from execute
//   data_sram_data_ok, data_sram_rdata  data SRAM response
//   flush                       exception/ertn taken in write-back
//   wb_allow_in / mem_to_wb_valid   handshake with write-back
//   mem_pc, mem_final_result, mem_gr_we, mem_dest, mem_ex_type  payload out
//   mem_fwd_we, mem_fwd_dest, mem_fwd_data  forwarding to decode
//   mem_load_pending            decode must stall
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_mem_valid,
  output logic        mem_allow_in,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  ex_load_op,
  input  logic        ex_gr_we,
  input  logic [4:0]  ex_dest,
  input  logic        ex_req_issued,
  input  logic [5:0]  ex_ex_type,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  input  logic        wb_allow_in,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_final_result,
  output logic        mem_gr_we,
  output logic [4:0]  mem_dest,
  output logic [5:0]  mem_ex_type,
  output logic        mem_fwd_we,
  output logic [4:0]  mem_fwd_dest,
  output logic [31:0] mem_fwd_data,
  output logic        mem_load_pending
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_valid_q, mem_valid_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic             resp_buf_valid_q, resp_buf_valid_d;
  logic [31:0]      resp_buf_q, resp_buf_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      alu_result_q, alu_result_d;
  logic [4:0]       load_op_q, load_op_d;
  logic             gr_we_q, gr_we_d;
  logic [4:0]       dest_q, dest_d;
  logic [5:0]       ex_type_q, ex_type_d;

  logic        resp_ok;
  logic        mem_ready_go;
  logic        accept;
  logic        handoff;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] load_word;

  // Select and extend the addressed byte/halfword of a load response.
  // load_op is one-hot {ld.w, ld.hu, ld.h, ld.bu, ld.b}.
  function automatic logic [31:0] align_load(input logic [4:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] word);
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] res;
    shifted = word >> {addr, 3'b000};
    half    = addr[1] ? word[31:16] : word[15:0];
    res     = word;
    if (op[0])      res = {{24{shifted[7]}}, shifted[7:0]};
    else if (op[1]) res = {24'd0, shifted[7:0]};
    else if (op[2]) res = {{16{half[15]}}, half};
    else if (op[3]) res = {16'd0, half};
    return res;
  endfunction

  // A response is consumed only when no stale responses are still owed to
  // killed instructions; otherwise it belongs to one of those and is dropped.
  assign resp_ok      = data_sram_data_ok & (discard_cnt_q == '0);
  assign mem_ready_go = (state_q == S_HOLD) | ((state_q == S_WAIT) & resp_ok);
  assign mem_allow_in = ~mem_valid_q | (mem_ready_go & wb_allow_in);
  assign accept       = ex_to_mem_valid & mem_allow_in & ~flush;
  assign mem_to_wb_valid = mem_valid_q & mem_ready_go & ~flush;
  assign handoff      = mem_to_wb_valid & wb_allow_in;

  // A flush while waiting leaves one request outstanding, unless its
  // response is arriving in this very cycle.
  assign cnt_inc = flush & mem_valid_q & (state_q == S_WAIT) & ~resp_ok;
  assign cnt_dec = data_sram_data_ok & (discard_cnt_q != '0);

  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (cnt_inc && !cnt_dec && discard_cnt_q != CNT_MAX)
      discard_cnt_d = discard_cnt_q + 1'b1;
    else if (cnt_dec && !cnt_inc)
      discard_cnt_d = discard_cnt_q - 1'b1;
  end

  always_comb begin
    state_d          = state_q;
    mem_valid_d      = mem_valid_q;
    resp_buf_valid_d = resp_buf_valid_q;
    resp_buf_d       = resp_buf_q;
    pc_d             = pc_q;
    alu_result_d     = alu_result_q;
    load_op_d        = load_op_q;
    gr_we_d          = gr_we_q;
    dest_d           = dest_q;
    ex_type_d        = ex_type_q;
    if (flush) begin
      state_d          = S_IDLE;
      mem_valid_d      = 1'b0;
      resp_buf_valid_d = 1'b0;
    end else if (accept) begin
      state_d          = ex_req_issued ? S_WAIT : S_HOLD;
      mem_valid_d      = 1'b1;
      resp_buf_valid_d = 1'b0;
      pc_d             = ex_pc;
      alu_result_d     = ex_alu_result;
      load_op_d        = ex_load_op;
      gr_we_d          = ex_gr_we;
      dest_d           = ex_dest;
      ex_type_d        = ex_ex_type;
    end else if (handoff) begin
      state_d          = S_IDLE;
      mem_valid_d      = 1'b0;
      resp_buf_valid_d = 1'b0;
    end else if (state_q == S_WAIT && resp_ok) begin
      // Write-back stalled in the arrival cycle: keep the word for later.
      state_d          = S_HOLD;
      resp_buf_d       = data_sram_rdata;
      resp_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      mem_valid_q      <= 1'b0;
      discard_cnt_q    <= '0;
      resp_buf_valid_q <= 1'b0;
      resp_buf_q       <= '0;
      pc_q             <= '0;
      alu_result_q     <= '0;
      load_op_q        <= '0;
      gr_we_q          <= 1'b0;
      dest_q           <= '0;
      ex_type_q        <= '0;
    end else begin
      state_q          <= state_d;
      mem_valid_q      <= mem_valid_d;
      discard_cnt_q    <= discard_cnt_d;
      resp_buf_valid_q <= resp_buf_valid_d;
      resp_buf_q       <= resp_buf_d;
      pc_q             <= pc_d;
      alu_result_q     <= alu_result_d;
      load_op_q        <= load_op_d;
      gr_we_q          <= gr_we_d;
      dest_q           <= dest_d;
      ex_type_q        <= ex_type_d;
    end
  end

  // Zero-latency bypass: use the live response until it has been buffered.
  assign load_word = resp_buf_valid_q ? resp_buf_q : data_sram_rdata;

  // Faulting instructions report the bad virtual address, not load data.
  assign mem_final_result = ((ex_type_q != '0) || (load_op_q == '0)) ?
                            alu_result_q :
                            align_load(load_op_q, alu_result_q[1:0], load_word);

  assign mem_pc      = pc_q;
  assign mem_gr_we   = gr_we_q;
  assign mem_dest    = dest_q;
  assign mem_ex_type = ex_type_q;

`ifdef MEM_FWD_EN
  assign mem_fwd_we       = mem_valid_q & gr_we_q & mem_ready_go & (ex_type_q == '0);
  assign mem_fwd_dest     = dest_q;
  assign mem_fwd_data     = mem_final_result;
  assign mem_load_pending = mem_valid_q & (|load_op_q) & ~mem_ready_go;
`else
  assign mem_fwd_we       = 1'b0;
  assign mem_fwd_dest     = '0;
  assign mem_fwd_data     = '0;
  assign mem_load_pending = mem_valid_q & gr_we_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- scoreboard bench for mem_stage. Stimulus pushes the
// expected write-back payload when an instruction is accepted; a monitor
// pops and compares whenever the DUT hands an instruction to write-back.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ex_to_mem_valid;
  logic        mem_allow_in;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_result;
  logic [4:0]  ex_load_op;
  logic        ex_gr_we;
  logic [4:0]  ex_dest;
  logic        ex_req_issued;
  logic [5:0]  ex_ex_type;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_final_result;
  logic        mem_gr_we;
  logic [4:0]  mem_dest;
  logic [5:0]  mem_ex_type;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_dest;
  logic [31:0] mem_fwd_data;
  logic        mem_load_pending;

  mem_stage #(.MAX_OUTSTANDING(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .mem_allow_in      (mem_allow_in),
    .ex_pc             (ex_pc),
    .ex_alu_result     (ex_alu_result),
    .ex_load_op        (ex_load_op),
    .ex_gr_we          (ex_gr_we),
    .ex_dest           (ex_dest),
    .ex_req_issued     (ex_req_issued),
    .ex_ex_type        (ex_ex_type),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .wb_allow_in       (wb_allow_in),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_pc            (mem_pc),
    .mem_final_result  (mem_final_result),
    .mem_gr_we         (mem_gr_we),
    .mem_dest          (mem_dest),
    .mem_ex_type       (mem_ex_type),
    .mem_fwd_we        (mem_fwd_we),
    .mem_fwd_dest      (mem_fwd_dest),
    .mem_fwd_data      (mem_fwd_data),
    .mem_load_pending  (mem_load_pending)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  dest;
    logic [5:0]  ex_type;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completed handoff must match the oldest expected entry.
  always @(negedge clk) begin
    if (resetn && mem_to_wb_valid && wb_allow_in) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: pc 0x%08h result 0x%08h with empty scoreboard",
                 mem_pc, mem_final_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", mem_pc, e.pc);
        check("sb_result", mem_final_result, e.res);
        check("sb_dest", 32'(mem_dest), 32'(e.dest));
        check("sb_ex_type", 32'(mem_ex_type), 32'(e.ex_type));
      end
    end
  end

  // Present one instruction and hold it until accepted; returns 1 ns after
  // the accepting edge. Killed instructions are not pushed.
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] op, input logic [4:0] dst,
                       input logic req, input logic [5:0] ext,
                       input logic [31:0] exp_res, input bit push);
    bit done;
    done            = 1'b0;
    ex_pc           = pc;
    ex_alu_result   = alu;
    ex_load_op      = op;
    ex_gr_we        = 1'b1;
    ex_dest         = dst;
    ex_req_issued   = req;
    ex_ex_type      = ext;
    ex_to_mem_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (mem_allow_in && !flush) begin
        done = 1'b1;
        if (push) sb.push_back('{pc: pc, res: exp_res, dest: dst, ex_type: ext});
      end
      @(posedge clk);
      #1;
    end
    ex_to_mem_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: pc 0x%08h never accepted", pc);
    end
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    resetn            = 1'b0;
    ex_to_mem_valid   = 1'b0;
    ex_pc             = '0;
    ex_alu_result     = '0;
    ex_load_op        = '0;
    ex_gr_we          = 1'b0;
    ex_dest           = '0;
    ex_req_issued     = 1'b0;
    ex_ex_type        = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    flush             = 1'b0;
    wb_allow_in       = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(mem_to_wb_valid), 0);
    check("rst_allow_in", 32'(mem_allow_in), 1);
    check("rst_pending", 32'(mem_load_pending), 0);
    check("rst_result", mem_final_result, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // ld.b at 0x1003, response two cycles after accept, bypassed
    issue(32'h100, 32'h1003, 5'b00001, 5'd3, 1'b1, 6'd0, 32'hFFFFFF80, 1'b1);
    @(negedge clk);
    check("ldb_wait_valid", 32'(mem_to_wb_valid), 0);
    check("ldb_wait_pending", 32'(mem_load_pending), 1);
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80AABBCC;
    @(negedge clk);
    check("ldb_dataok_valid", 32'(mem_to_wb_valid), 1);
`ifndef MEM_FWD_EN
    check("fwd_we_off", 32'(mem_fwd_we), 0);
`endif
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;

    // ld.hu then ld.h at 0x1002; ld.h response buffered while write-back stalls
    issue(32'h104, 32'h1002, 5'b01000, 5'd4, 1'b1, 6'd0, 32'h00008001, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80011234;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    issue(32'h108, 32'h1002, 5'b00100, 5'd5, 1'b1, 6'd0, 32'hFFFF8001, 1'b1);
    wb_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80011234;
    @(negedge clk);
    check("ldh_bypass_result", mem_final_result, 32'hFFFF8001);
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEADBEEF;
    @(negedge clk);
    check("ldh_held_valid", 32'(mem_to_wb_valid), 1);
    check("ldh_held_result", mem_final_result, 32'hFFFF8001);
    @(posedge clk);
    #1;
    wb_allow_in = 1'b1;
    @(posedge clk);
    #1;

    // Non-memory add, write-back stalled for three cycles
    wb_allow_in = 1'b0;
    issue(32'h10C, 32'h55, 5'b00000, 5'd6, 1'b0, 6'd0, 32'h55, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("add_stall_valid", 32'(mem_to_wb_valid), 1);
      check("add_stall_result", mem_final_result, 32'h55);
      check("add_stall_pc", mem_pc, 32'h10C);
      check("add_stall_allow_in", 32'(mem_allow_in), 0);
      @(posedge clk);
      #1;
    end
    wb_allow_in = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("add_after_handoff", 32'(mem_to_wb_valid), 0);
    @(posedge clk);
    #1;

    // Flush while waiting: stale response discarded, fresh one delivered
    issue(32'h200, 32'h2000, 5'b10000, 5'd7, 1'b1, 6'd0, 32'h0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", 32'(mem_to_wb_valid), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("discard_after_flush", 32'(dut.discard_cnt_q), 1);
    issue(32'h204, 32'h2004, 5'b10000, 5'd8, 1'b1, 6'd0, 32'h1234, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000DEAD;
    @(negedge clk);
    check("stale_dropped", 32'(mem_to_wb_valid), 0);
    @(posedge clk);
    #1;
    check("discard_drained", 32'(dut.discard_cnt_q), 0);
    data_sram_rdata = 32'h00001234;
    @(negedge clk);
    check("fresh_valid", 32'(mem_to_wb_valid), 1);
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;

    // Discard counter saturates at MAX_OUTSTANDING (2)
    issue(32'h210, 32'h2010, 5'b10000, 5'd1, 1'b1, 6'd0, 32'h0, 1'b0);
    flush_pulse();
    issue(32'h214, 32'h2014, 5'b10000, 5'd1, 1'b1, 6'd0, 32'h0, 1'b0);
    flush_pulse();
    issue(32'h218, 32'h2018, 5'b10000, 5'd1, 1'b1, 6'd0, 32'h0, 1'b0);
    flush_pulse();
    check("discard_saturated", 32'(dut.discard_cnt_q), 2);
    issue(32'h21C, 32'h201C, 5'b10000, 5'd2, 1'b1, 6'd0, 32'hCAFE0000, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11111111;
    @(posedge clk);
    #1;
    data_sram_rdata = 32'h22222222;
    @(posedge clk);
    #1;
    data_sram_rdata = 32'hCAFE0000;
    @(negedge clk);
    check("sat_fresh_valid", 32'(mem_to_wb_valid), 1);
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;

    // ALE on a misaligned ld.w: bad address reported, no response awaited
    issue(32'h300, 32'h1001, 5'b10000, 5'd9, 1'b0, 6'b000100, 32'h1001, 1'b1);
    @(negedge clk);
    check("ale_valid", 32'(mem_to_wb_valid), 1);
    check("ale_ex_type", 32'(mem_ex_type), 32'h4);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of WAIT
    issue(32'h400, 32'h3000, 5'b10000, 5'd10, 1'b1, 6'd0, 32'h0, 1'b0);
    wb_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h77;
    @(negedge clk);
    check("pre_reset_valid", 32'(mem_to_wb_valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_valid", 32'(mem_to_wb_valid), 0);
    check("async_rst_state", 32'(dut.state_q), 0);
    check("async_rst_allow_in", 32'(mem_allow_in), 1);
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    @(posedge clk);
    #1;
    resetn      = 1'b1;
    wb_allow_in = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
